// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID pipeline register for the 5-stage ARM pipeline.
// Holds the PC, applies execute-stage redirects (two-bubble penalty) and keeps saturating counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             ex_is_branch,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    output logic [31:0]      pc,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc_plus_4,
    output logic             if_id_valid,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] redirect_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + CNT_ONE;
        end
        return result;
    endfunction

    logic [31:0]      pc_r;
    logic [31:0]      instr_r;
    logic [31:0]      pc_plus_4_r;
    logic             valid_r;
    logic [CNT_W-1:0] fetch_cnt_r;
    logic [CNT_W-1:0] redirect_cnt_r;

    logic             redirect_s;
    logic [31:0]      pc_plus_4_s;
    logic [31:0]      pc_next_s;
    logic [31:0]      instr_next_s;
    logic [31:0]      pc_plus_4_next_s;
    logic             valid_next_s;
    logic [CNT_W-1:0] fetch_cnt_next_s;
    logic [CNT_W-1:0] redirect_cnt_next_s;

    assign redirect_s  = ex_is_branch & branch_taken;
    assign pc_plus_4_s = pc_r + 32'd4;

    // Next-state selection: redirect beats stall, stall beats advance.
    always_comb begin
        pc_next_s           = pc_r;
        instr_next_s        = instr_r;
        pc_plus_4_next_s    = pc_plus_4_r;
        valid_next_s        = valid_r;
        fetch_cnt_next_s    = fetch_cnt_r;
        redirect_cnt_next_s = redirect_cnt_r;
        if (redirect_s) begin
            // The instruction held in ID is wrong-path even when stalled, so it is dropped.
            pc_next_s           = {branch_target[31:2], 2'b00};
            instr_next_s        = 32'h0000_0000;
            pc_plus_4_next_s    = 32'h0000_0000;
            valid_next_s        = 1'b0;
            redirect_cnt_next_s = sat_inc(redirect_cnt_r);
        end else if (stall) begin
            pc_next_s           = pc_r;
        end else begin
            pc_next_s           = pc_plus_4_s;
            instr_next_s        = imem_data;
            pc_plus_4_next_s    = pc_plus_4_s;
            valid_next_s        = 1'b1;
            fetch_cnt_next_s    = sat_inc(fetch_cnt_r);
        end
    end

    // PC, IF/ID register and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r           <= RESET_PC;
            instr_r        <= 32'h0000_0000;
            pc_plus_4_r    <= 32'h0000_0000;
            valid_r        <= 1'b0;
            fetch_cnt_r    <= {CNT_W{1'b0}};
            redirect_cnt_r <= {CNT_W{1'b0}};
        end else begin
            pc_r           <= pc_next_s;
            instr_r        <= instr_next_s;
            pc_plus_4_r    <= pc_plus_4_next_s;
            valid_r        <= valid_next_s;
            fetch_cnt_r    <= fetch_cnt_next_s;
            redirect_cnt_r <= redirect_cnt_next_s;
        end
    end

    // Flush must reach ID/EX on the same edge the redirect lands, so it stays combinational.
    assign id_ex_flush     = redirect_s;
    assign imem_addr       = pc_r;
    assign pc              = pc_r;
    assign if_id_instr     = instr_r;
    assign if_id_pc_plus_4 = pc_plus_4_r;
    assign if_id_valid     = valid_r;
    assign fetch_count     = fetch_cnt_r;
    assign redirect_count  = redirect_cnt_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: one default instance and one with
// RESET_PC near the top of memory and 4-bit counters for wrap and saturation.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, stall, ex_is_branch, branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr, imem_data, pc, if_id_instr, if_id_pc_plus_4;
    logic        if_id_valid, id_ex_flush;
    logic [15:0] fetch_count, redirect_count;

    logic        reset2, stall2, exb2, bt2;
    logic [31:0] tgt2, imem_addr2, imem_data2, pc2, instr2, ppc4_2;
    logic        valid2, flush2;
    logic [3:0]  fcnt2, rcnt2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Memory word at byte address a is 32'hE000_0000 + a/4.
    assign imem_data  = 32'hE000_0000 + (imem_addr >> 2);
    assign imem_data2 = 32'hE000_0000 + (imem_addr2 >> 2);

    fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .ex_is_branch(ex_is_branch),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_data(imem_data), .pc(pc),
        .if_id_instr(if_id_instr), .if_id_pc_plus_4(if_id_pc_plus_4),
        .if_id_valid(if_id_valid), .id_ex_flush(id_ex_flush),
        .fetch_count(fetch_count), .redirect_count(redirect_count)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(4)) dut2 (
        .clk(clk), .reset(reset2), .stall(stall2), .ex_is_branch(exb2),
        .branch_taken(bt2), .branch_target(tgt2),
        .imem_addr(imem_addr2), .imem_data(imem_data2), .pc(pc2),
        .if_id_instr(instr2), .if_id_pc_plus_4(ppc4_2),
        .if_id_valid(valid2), .id_ex_flush(flush2),
        .fetch_count(fcnt2), .redirect_count(rcnt2)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; stall = 1'b0; ex_is_branch = 1'b1; branch_taken = 1'b1;
        branch_target = 32'h0000_0000;
        #2;
        n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 00000000", pc); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_imem_addr: got %h want 00000000", imem_addr); end
        n_cmp++; if ({if_id_instr, if_id_pc_plus_4, if_id_valid} !== 65'h0) begin n_bad++; $display("FAIL reset_ifid: got %h %h %b want 0 0 0", if_id_instr, if_id_pc_plus_4, if_id_valid); end
        n_cmp++; if ({fetch_count, redirect_count} !== 32'h0) begin n_bad++; $display("FAIL reset_counts: got %0d %0d want 0 0", fetch_count, redirect_count); end
        n_cmp++; if (id_ex_flush !== 1'b1) begin n_bad++; $display("FAIL reset_flush_comb: got %b want 1", id_ex_flush); end
        ex_is_branch = 1'b0; branch_taken = 1'b0;
        #1;
        n_cmp++; if (id_ex_flush !== 1'b0) begin n_bad++; $display("FAIL reset_flush_low: got %b want 0", id_ex_flush); end
        tick(2);
        n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL reset_hold_pc: got %h want 00000000", pc); end
    endtask

    task automatic test_fetch();
        reset = 1'b1;
        tick(3);
        n_cmp++; if (if_id_instr !== 32'hE000_0002) begin n_bad++; $display("FAIL fetch_instr: got %h want e0000002", if_id_instr); end
        n_cmp++; if (if_id_pc_plus_4 !== 32'd12) begin n_bad++; $display("FAIL fetch_ppc4: got %h want 0000000c", if_id_pc_plus_4); end
        n_cmp++; if (pc !== 32'd12) begin n_bad++; $display("FAIL fetch_pc: got %h want 0000000c", pc); end
        n_cmp++; if (fetch_count !== 16'd3) begin n_bad++; $display("FAIL fetch_count: got %0d want 3", fetch_count); end
        n_cmp++; if (if_id_valid !== 1'b1) begin n_bad++; $display("FAIL fetch_valid: got %b want 1", if_id_valid); end
    endtask

    task automatic test_stall();
        reset = 1'b0; #1; reset = 1'b1;
        tick(2);
        stall = 1'b1;
        tick(2);
        n_cmp++; if (pc !== 32'd8) begin n_bad++; $display("FAIL stall_pc: got %h want 00000008", pc); end
        n_cmp++; if (imem_addr !== 32'd8) begin n_bad++; $display("FAIL stall_imem_addr: got %h want 00000008", imem_addr); end
        n_cmp++; if (if_id_instr !== 32'hE000_0001) begin n_bad++; $display("FAIL stall_instr: got %h want e0000001", if_id_instr); end
        n_cmp++; if (fetch_count !== 16'd2) begin n_bad++; $display("FAIL stall_count: got %0d want 2", fetch_count); end
        stall = 1'b0;
        tick(1);
        n_cmp++; if (if_id_instr !== 32'hE000_0002) begin n_bad++; $display("FAIL stall_release_instr: got %h want e0000002", if_id_instr); end
        n_cmp++; if ({pc, if_id_pc_plus_4} !== {32'd12, 32'd12}) begin n_bad++; $display("FAIL stall_release_pc: got %h %h want c c", pc, if_id_pc_plus_4); end
        n_cmp++; if (fetch_count !== 16'd3) begin n_bad++; $display("FAIL stall_release_count: got %0d want 3", fetch_count); end
    endtask

    task automatic test_branch();
        tick(1);
        n_cmp++; if (pc !== 32'd16) begin n_bad++; $display("FAIL branch_pre_pc: got %h want 00000010", pc); end
        ex_is_branch = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0103;
        #1;
        n_cmp++; if (id_ex_flush !== 1'b1) begin n_bad++; $display("FAIL branch_flush: got %b want 1", id_ex_flush); end
        tick(1);
        ex_is_branch = 1'b0; branch_taken = 1'b0;
        n_cmp++; if (pc !== 32'h100) begin n_bad++; $display("FAIL branch_pc: got %h want 00000100", pc); end
        n_cmp++; if ({if_id_valid, if_id_instr, if_id_pc_plus_4} !== 65'h0) begin n_bad++; $display("FAIL branch_bubble: got %b %h %h want 0 0 0", if_id_valid, if_id_instr, if_id_pc_plus_4); end
        n_cmp++; if ({redirect_count, fetch_count} !== {16'd1, 16'd4}) begin n_bad++; $display("FAIL branch_counts: got %0d %0d want 1 4", redirect_count, fetch_count); end
        #1;
        n_cmp++; if (id_ex_flush !== 1'b0) begin n_bad++; $display("FAIL branch_flush_drop: got %b want 0", id_ex_flush); end
        tick(1);
        n_cmp++; if (if_id_pc_plus_4 !== 32'h104) begin n_bad++; $display("FAIL branch_target_ppc4: got %h want 00000104", if_id_pc_plus_4); end
        n_cmp++; if ({if_id_instr, if_id_valid} !== {32'hE000_0040, 1'b1}) begin n_bad++; $display("FAIL branch_target_instr: got %h %b want e0000040 1", if_id_instr, if_id_valid); end
    endtask

    task automatic test_redirect_stall();
        stall = 1'b1; ex_is_branch = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0200;
        tick(1);
        n_cmp++; if (pc !== 32'h200) begin n_bad++; $display("FAIL rs_pc: got %h want 00000200", pc); end
        n_cmp++; if (if_id_valid !== 1'b0) begin n_bad++; $display("FAIL rs_bubble: got %b want 0", if_id_valid); end
        n_cmp++; if ({redirect_count, fetch_count} !== {16'd2, 16'd5}) begin n_bad++; $display("FAIL rs_counts: got %0d %0d want 2 5", redirect_count, fetch_count); end
        ex_is_branch = 1'b0; branch_target = 32'h0000_0800;
        #1;
        n_cmp++; if (id_ex_flush !== 1'b0) begin n_bad++; $display("FAIL unqual_flush: got %b want 0", id_ex_flush); end
        tick(1);
        n_cmp++; if ({pc, redirect_count} !== {32'h200, 16'd2}) begin n_bad++; $display("FAIL unqual_stall: got %h %0d want 200 2", pc, redirect_count); end
        stall = 1'b0;
        tick(1);
        branch_taken = 1'b0;
        n_cmp++; if ({pc, if_id_instr, if_id_valid} !== {32'h204, 32'hE000_0080, 1'b1}) begin n_bad++; $display("FAIL unqual_advance: got %h %h %b want 204 e0000080 1", pc, if_id_instr, if_id_valid); end
        n_cmp++; if ({fetch_count, redirect_count} !== {16'd6, 16'd2}) begin n_bad++; $display("FAIL unqual_counts: got %0d %0d want 6 2", fetch_count, redirect_count); end
    endtask

    task automatic test_back_to_back();
        ex_is_branch = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0300;
        tick(1);
        branch_target = 32'h0000_040B;
        tick(1);
        ex_is_branch = 1'b0; branch_taken = 1'b0;
        n_cmp++; if ({pc, if_id_valid} !== {32'h408, 1'b0}) begin n_bad++; $display("FAIL b2b_pc: got %h %b want 408 0", pc, if_id_valid); end
        n_cmp++; if (redirect_count !== 16'd4) begin n_bad++; $display("FAIL b2b_count: got %0d want 4", redirect_count); end
        tick(1);
        n_cmp++; if ({if_id_instr, if_id_pc_plus_4} !== {32'hE000_0102, 32'h40C}) begin n_bad++; $display("FAIL b2b_target: got %h %h want e0000102 40c", if_id_instr, if_id_pc_plus_4); end
        n_cmp++; if (fetch_count !== 16'd7) begin n_bad++; $display("FAIL b2b_fetch_count: got %0d want 7", fetch_count); end
    endtask

    task automatic test_async_reset();
        stall = 1'b1; ex_is_branch = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0500;
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if ({pc, imem_addr} !== 64'h0) begin n_bad++; $display("FAIL async_pc: got %h %h want 0 0", pc, imem_addr); end
        n_cmp++; if ({if_id_instr, if_id_pc_plus_4, if_id_valid} !== 65'h0) begin n_bad++; $display("FAIL async_ifid: got %h %h %b want 0 0 0", if_id_instr, if_id_pc_plus_4, if_id_valid); end
        n_cmp++; if ({fetch_count, redirect_count} !== 32'h0) begin n_bad++; $display("FAIL async_counts: got %0d %0d want 0 0", fetch_count, redirect_count); end
        stall = 1'b0; ex_is_branch = 1'b0; branch_taken = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);
        n_cmp++; if ({pc, if_id_instr} !== {32'd4, 32'hE000_0000}) begin n_bad++; $display("FAIL async_restart: got %h %h want 4 e0000000", pc, if_id_instr); end
    endtask

    task automatic test_wrap_saturate();
        reset2 = 1'b1;
        tick(1);
        n_cmp++; if ({pc2, instr2} !== {32'hFFFF_FFFC, 32'h1FFF_FFFE}) begin n_bad++; $display("FAIL wrap_first: got %h %h want fffffffc 1ffffffe", pc2, instr2); end
        tick(1);
        n_cmp++; if ({pc2, imem_addr2, ppc4_2} !== 96'h0) begin n_bad++; $display("FAIL wrap_pc: got %h %h %h want 0 0 0", pc2, imem_addr2, ppc4_2); end
        n_cmp++; if (instr2 !== 32'h1FFF_FFFF) begin n_bad++; $display("FAIL wrap_instr: got %h want 1fffffff", instr2); end
        tick(13);
        n_cmp++; if (fcnt2 !== 4'd15) begin n_bad++; $display("FAIL sat_reach: got %0d want 15", fcnt2); end
        tick(5);
        n_cmp++; if (fcnt2 !== 4'd15) begin n_bad++; $display("FAIL sat_hold: got %0d want 15", fcnt2); end
        n_cmp++; if (pc2 !== 32'h48) begin n_bad++; $display("FAIL sat_pc: got %h want 00000048", pc2); end
        #2;
        reset2 = 1'b0;
        #1;
        n_cmp++; if ({pc2, fcnt2, valid2} !== {32'hFFFF_FFF8, 4'd0, 1'b0}) begin n_bad++; $display("FAIL sat_async: got %h %0d %b want fffffff8 0 0", pc2, fcnt2, valid2); end
    endtask

    initial begin
        reset2 = 1'b0; stall2 = 1'b0; exb2 = 1'b0; bt2 = 1'b0; tgt2 = 32'h0000_0000;
        test_reset();
        test_fetch();
        test_stall();
        test_branch();
        test_redirect_stall();
        test_back_to_back();
        test_async_reset();
        test_wrap_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
